// File: rtl/iob_cache_req_master.sv
`default_nettype none
// ============================================================================
//  Module   : iob_cache_req_master
//  Purpose  : IOb-bus initiator for the cache front-end request port. It turns
//             a valid/ready command stream into single IOb transactions, with
//             at most one in flight, and returns read data on a buffered
//             valid/ready response stream. It also keeps read/write counters,
//             a read-timeout monitor and an unexpected-rvalid monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module iob_cache_req_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,
    // command stream
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    input  logic [DATA_W/8-1:0] cmd_wstrb_i,
    input  logic [3:0]          cmd_acache_i,
    // response stream
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    // IOb bus
    output logic                iob_avalid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    output logic [3:0]          iob_acache_o,
    input  logic                iob_ready_i,
    input  logic                iob_rvalid_i,
    input  logic [DATA_W-1:0]   iob_rdata_i,
    // monitors
    input  logic                clr_i,
    output logic [CNT_W-1:0]    rd_cnt_o,
    output logic [CNT_W-1:0]    wr_cnt_o,
    output logic                timeout_o,
    output logic                err_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_WAIT_RD = 2'd2;
    localparam logic [1:0] S_RSP     = 2'd3;

    // Wait counter only needs to reach TIMEOUT, where it saturates.
    localparam int              c_TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_TO_W-1:0] c_TO_MAX  = c_TO_W'(TIMEOUT);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]          r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [3:0]          r_acache;
    logic [DATA_W-1:0]   r_rdata;
    logic [c_TO_W-1:0]   r_tcnt;
    logic [CNT_W-1:0]    r_rd_cnt;
    logic [CNT_W-1:0]    r_wr_cnt;
    logic                r_timeout;
    logic                r_err;

    logic w_bus_acc;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_to_hit;
    logic w_bad_rvalid;

    assign w_bus_acc    = (r_state == S_REQ) && iob_ready_i;
    assign w_wr_acc     = w_bus_acc && (|r_wstrb);
    assign w_rd_acc     = w_bus_acc && !(|r_wstrb);
    // Flag rises on the edge where the wait counter steps onto TIMEOUT.
    assign w_to_hit     = (TIMEOUT != 0) && (r_state == S_WAIT_RD) && !iob_rvalid_i
                          && (r_tcnt == c_TO_LAST);
    assign w_bad_rvalid = iob_rvalid_i && (r_state != S_WAIT_RD);

    // Transaction FSM: command capture, bus request, read wait, response hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_acache <= '0;
            r_rdata  <= '0;
            r_tcnt   <= '0;
        end else if (cke_i) begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_addr   <= cmd_addr_i;
                        r_wdata  <= cmd_wdata_i;
                        r_wstrb  <= cmd_wstrb_i;
                        r_acache <= cmd_acache_i;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (iob_ready_i) begin
                        if (|r_wstrb) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_tcnt  <= '0;
                            r_state <= S_WAIT_RD;
                        end
                    end
                end
                S_WAIT_RD: begin
                    if (iob_rvalid_i) begin
                        r_rdata <= iob_rdata_i;
                        r_state <= S_RSP;
                    end else if ((TIMEOUT != 0) && (r_tcnt != c_TO_MAX)) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: begin
                    if (rsp_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Transaction counters and sticky flags; clear has priority over updates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_timeout <= 1'b0;
            r_err     <= 1'b0;
        end else if (cke_i) begin
            if (clr_i) begin
                r_rd_cnt  <= '0;
                r_wr_cnt  <= '0;
                r_timeout <= 1'b0;
                r_err     <= 1'b0;
            end else begin
                if (w_rd_acc)     r_rd_cnt  <= r_rd_cnt + 1'b1;
                if (w_wr_acc)     r_wr_cnt  <= r_wr_cnt + 1'b1;
                if (w_to_hit)     r_timeout <= 1'b1;
                if (w_bad_rvalid) r_err     <= 1'b1;
            end
        end
    end

    assign cmd_ready_o  = (r_state == S_IDLE);
    assign iob_avalid_o = (r_state == S_REQ);
    assign iob_addr_o   = r_addr;
    assign iob_wdata_o  = r_wdata;
    assign iob_wstrb_o  = r_wstrb;
    assign iob_acache_o = r_acache;
    assign rsp_valid_o  = (r_state == S_RSP);
    assign rsp_rdata_o  = r_rdata;
    assign rd_cnt_o     = r_rd_cnt;
    assign wr_cnt_o     = r_wr_cnt;
    assign timeout_o    = r_timeout;
    assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_iob_cache_req_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iob_cache_req_master
//  Purpose  : Directed self-checking bench for iob_cache_req_master.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iob_cache_req_master;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cke = 1'b1;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [ADDR_W-1:0]   cmd_addr = '0;
    logic [DATA_W-1:0]   cmd_wdata = '0;
    logic [DATA_W/8-1:0] cmd_wstrb = '0;
    logic [3:0]          cmd_acache = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                iob_avalid;
    logic [ADDR_W-1:0]   iob_addr;
    logic [DATA_W-1:0]   iob_wdata;
    logic [DATA_W/8-1:0] iob_wstrb;
    logic [3:0]          iob_acache;
    logic                iob_ready = 1'b0;
    logic                iob_rvalid = 1'b0;
    logic [DATA_W-1:0]   iob_rdata = '0;
    logic                clr = 1'b0;
    logic [CNT_W-1:0]    rd_cnt;
    logic [CNT_W-1:0]    wr_cnt;
    logic                timeout;
    logic                err;

    int n_cmp = 0;
    int n_bad = 0;

    iob_cache_req_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cke_i       (cke),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .cmd_wstrb_i (cmd_wstrb),
        .cmd_acache_i(cmd_acache),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .iob_avalid_o(iob_avalid),
        .iob_addr_o  (iob_addr),
        .iob_wdata_o (iob_wdata),
        .iob_wstrb_o (iob_wstrb),
        .iob_acache_o(iob_acache),
        .iob_ready_i (iob_ready),
        .iob_rvalid_i(iob_rvalid),
        .iob_rdata_i (iob_rdata),
        .clr_i       (clr),
        .rd_cnt_o    (rd_cnt),
        .wr_cnt_o    (wr_cnt),
        .timeout_o   (timeout),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample and drive 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (iob_avalid !== 1'b0) begin n_bad++; $display("FAIL reset_avalid: got %b want 0", iob_avalid); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if ({iob_addr, iob_wdata, iob_wstrb, iob_acache} !== '0) begin n_bad++; $display("FAIL reset_iob_fields: got %h/%h/%h/%h want 0", iob_addr, iob_wdata, iob_wstrb, iob_acache); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        n_cmp++; if ({rd_cnt, wr_cnt, timeout, err} !== 10'h0) begin n_bad++; $display("FAIL reset_monitors: got rd=%0d wr=%0d to=%b err=%b want 0", rd_cnt, wr_cnt, timeout, err); end
    endtask

    task automatic test_write();
        cmd_valid = 1'b1; cmd_addr = 32'h100; cmd_wdata = 32'hDEADBEEF;
        cmd_wstrb = 4'hF; cmd_acache = 4'h3; iob_ready = 1'b1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL wr_cmd_ready_n: got %b want 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        n_cmp++; if (iob_avalid !== 1'b1) begin n_bad++; $display("FAIL wr_avalid_n1: got %b want 1", iob_avalid); end
        n_cmp++; if ({iob_addr, iob_wdata, iob_wstrb, iob_acache} !== {32'h100, 32'hDEADBEEF, 4'hF, 4'h3}) begin
            n_bad++; $display("FAIL wr_fields: got %h/%h/%h/%h want 100/deadbeef/f/3", iob_addr, iob_wdata, iob_wstrb, iob_acache); end
        tick();
        n_cmp++; if (iob_avalid !== 1'b0) begin n_bad++; $display("FAIL wr_avalid_n2: got %b want 0", iob_avalid); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL wr_cmd_ready_n2: got %b want 1", cmd_ready); end
        n_cmp++; if (wr_cnt !== 4'd1) begin n_bad++; $display("FAIL wr_cnt: got %0d want 1", wr_cnt); end
    endtask

    task automatic test_read_stall();
        iob_ready = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 32'h200; cmd_wdata = 32'h0; cmd_wstrb = 4'h0; cmd_acache = 4'h5;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) iob_ready = 1'b1;
            n_cmp++; if ({iob_avalid, iob_addr, iob_wstrb, iob_acache} !== {1'b1, 32'h200, 4'h0, 4'h5}) begin
                n_bad++; $display("FAIL rd_hold_%0d: got v=%b a=%h s=%h c=%h want 1/200/0/5", i, iob_avalid, iob_addr, iob_wstrb, iob_acache); end
            tick();
        end
        iob_ready = 1'b0;
        n_cmp++; if ({iob_avalid, rsp_valid} !== 2'b00) begin n_bad++; $display("FAIL rd_wait_idle_out: got avalid=%b rsp_valid=%b want 0/0", iob_avalid, rsp_valid); end
        n_cmp++; if (rd_cnt !== 4'd1) begin n_bad++; $display("FAIL rd_cnt: got %0d want 1", rd_cnt); end
        tick();
        iob_rvalid = 1'b1; iob_rdata = 32'h12345678;
        tick();
        iob_rvalid = 1'b0; iob_rdata = 32'h0;
        n_cmp++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h12345678}) begin n_bad++; $display("FAIL rd_rsp: got v=%b d=%h want 1/12345678", rsp_valid, rsp_rdata); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++; if ({cmd_ready, rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL rd_done: got ready=%b rsp_valid=%b want 1/0", cmd_ready, rsp_valid); end
    endtask

    task automatic test_rsp_backpressure();
        cmd_valid = 1'b1; cmd_addr = 32'h300; cmd_wstrb = 4'h0; iob_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        iob_ready = 1'b0; iob_rvalid = 1'b1; iob_rdata = 32'hA5A50001;
        tick();
        iob_rvalid = 1'b0; iob_rdata = 32'hFFFFFFFF;
        cmd_valid = 1'b1; cmd_addr = 32'h400; cmd_wdata = 32'h1; cmd_wstrb = 4'h1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({rsp_valid, rsp_rdata, cmd_ready} !== {1'b1, 32'hA5A50001, 1'b0}) begin
                n_bad++; $display("FAIL bp_hold_%0d: got v=%b d=%h ready=%b want 1/a5a50001/0", i, rsp_valid, rsp_rdata, cmd_ready); end
            tick();
        end
        rsp_ready = 1'b1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_same_cycle: got %b want 0", cmd_ready); end
        tick();
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        n_cmp++; if ({cmd_ready, rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL bp_release: got ready=%b rsp_valid=%b want 1/0", cmd_ready, rsp_valid); end
    endtask

    task automatic test_timeout();
        cmd_valid = 1'b1; cmd_addr = 32'h500; cmd_wstrb = 4'h0; iob_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        iob_ready = 1'b0;
        for (int w = 1; w <= 20; w++) begin
            tick();
            if (w == 6) begin
                n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL to_early: got %b want 0", timeout); end
            end
            if (w == 9) begin
                n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL to_set: got %b want 1", timeout); end
            end
        end
        iob_rvalid = 1'b1; iob_rdata = 32'h0BADF00D;
        tick();
        iob_rvalid = 1'b0;
        n_cmp++; if ({rsp_valid, rsp_rdata, timeout} !== {1'b1, 32'h0BADF00D, 1'b1}) begin
            n_bad++; $display("FAIL to_rsp: got v=%b d=%h to=%b want 1/0badf00d/1", rsp_valid, rsp_rdata, timeout); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++; if (rd_cnt !== 4'd3) begin n_bad++; $display("FAIL to_rd_cnt: got %0d want 3", rd_cnt); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++; if ({timeout, rd_cnt, wr_cnt} !== 9'h0) begin n_bad++; $display("FAIL clr: got to=%b rd=%0d wr=%0d want 0", timeout, rd_cnt, wr_cnt); end
    endtask

    task automatic test_err_and_reset();
        iob_rvalid = 1'b1; iob_rdata = 32'hCAFECAFE;
        tick();
        iob_rvalid = 1'b0;
        n_cmp++; if ({err, rsp_valid, cmd_ready} !== 3'b101) begin n_bad++; $display("FAIL err_idle: got err=%b rsp_valid=%b ready=%b want 1/0/1", err, rsp_valid, cmd_ready); end
        cmd_valid = 1'b1; cmd_addr = 32'h600; cmd_wstrb = 4'h0; iob_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        iob_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({cmd_ready, iob_avalid, rsp_valid, err, rd_cnt, iob_addr, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0}) begin
            n_bad++; $display("FAIL rst_mid: got ready=%b av=%b rv=%b err=%b rd=%0d a=%h d=%h want 1/0/0/0/0/0/0", cmd_ready, iob_avalid, rsp_valid, err, rd_cnt, iob_addr, rsp_rdata); end
        iob_rvalid = 1'b1; iob_rdata = 32'h55AA55AA;
        tick();
        iob_rvalid = 1'b0;
        n_cmp++; if ({err, rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL late_rvalid: got err=%b rsp_valid=%b want 1/0", err, rsp_valid); end
    endtask

    task automatic test_wrap_and_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        iob_ready = 1'b1; cmd_wstrb = 4'hC; cmd_addr = 32'h700;
        for (int i = 1; i <= 17; i++) begin
            cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            tick();
            if (i == 16) begin
                n_cmp++; if (wr_cnt !== 4'd0) begin n_bad++; $display("FAIL wrap_16: got %0d want 0", wr_cnt); end
            end
        end
        n_cmp++; if (wr_cnt !== 4'd1) begin n_bad++; $display("FAIL wrap_17: got %0d want 1", wr_cnt); end
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++; if ({wr_cnt, cmd_ready} !== {4'd0, 1'b1}) begin n_bad++; $display("FAIL clr_vs_inc: got wr=%0d ready=%b want 0/1", wr_cnt, cmd_ready); end
    endtask

    task automatic test_cke();
        cke = 1'b0; cmd_valid = 1'b1; iob_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if ({cmd_ready, iob_avalid} !== 2'b10) begin n_bad++; $display("FAIL cke_idle_hold: got ready=%b av=%b want 1/0", cmd_ready, iob_avalid); end
        cke = 1'b1;
        tick();
        cmd_valid = 1'b0; cke = 1'b0;
        tick();
        n_cmp++; if ({iob_avalid, wr_cnt} !== {1'b1, 4'd0}) begin n_bad++; $display("FAIL cke_req_hold: got av=%b wr=%0d want 1/0", iob_avalid, wr_cnt); end
        cke = 1'b1;
        tick();
        iob_ready = 1'b0;
        n_cmp++; if ({iob_avalid, wr_cnt} !== {1'b0, 4'd1}) begin n_bad++; $display("FAIL cke_resume: got av=%b wr=%0d want 0/1", iob_avalid, wr_cnt); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_stall();
        test_rsp_backpressure();
        test_timeout();
        test_err_and_reset();
        test_wrap_and_clr();
        test_cke();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got stuck want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/iob_cache_req_master.md
# iob_cache_req_master

IOb-bus initiator that drives the cache front-end request port (`iob_avalid`/`iob_ready`/`iob_rvalid`) from a valid/ready command stream. It returns read data on a buffered valid/ready response stream. It sits between an accelerator engine and the cache, with at most one IOb transaction in flight. It also keeps read/write counters, a read-timeout monitor and a protocol-error monitor.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width.
- `DATA_W`, 32, data width; `DATA_W/8` strobe bits.
- `CNT_W`, 16, width of the read and write transaction counters.
- `TIMEOUT`, 1024, read-wait cycles before `timeout_o` sets; 0 disables the monitor.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset; overrides `cke_i`.
- `cke_i`  in  1  clock enable; no register updates while 0.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  command accepted when `cmd_valid_i` & `cmd_ready_o`.
- `cmd_addr_i`  in  ADDR_W  address.
- `cmd_wdata_i`  in  DATA_W  write data.
- `cmd_wstrb_i`  in  DATA_W/8  byte strobes; nonzero = write, zero = read.
- `cmd_acache_i`  in  4  cache attributes.
- `rsp_valid_o`  out  1  read data available.
- `rsp_ready_i`  in  1  consumer takes the response.
- `rsp_rdata_o`  out  DATA_W  read data.
- `iob_avalid_o`  out  1  bus request valid.
- `iob_addr_o`  out  ADDR_W  bus address.
- `iob_wdata_o`  out  DATA_W  bus write data.
- `iob_wstrb_o`  out  DATA_W/8  bus strobes.
- `iob_acache_o`  out  4  bus cache attributes.
- `iob_ready_i`  in  1  responder can accept.
- `iob_rvalid_i`  in  1  read data valid.
- `iob_rdata_i`  in  DATA_W  read data.
- `clr_i`  in  1  clears counters and sticky flags.
- `rd_cnt_o`  out  CNT_W  reads accepted on the bus.
- `wr_cnt_o`  out  CNT_W  writes accepted on the bus.
- `timeout_o`  out  1  sticky read-timeout flag.
- `err_o`  out  1  sticky flag for unexpected `iob_rvalid_i`.

## Operation
- FSM states: IDLE, REQ, WAIT_RD, RSP. Reset state is IDLE.
- IDLE: `cmd_ready_o`=1. On handshake, register addr/wdata/wstrb/acache and go to REQ.
- REQ: `iob_avalid_o`=1, driven from the registered command fields. Fields are held stable until `iob_ready_i`=1.
  - On `iob_ready_i`=1 with a write (|wstrb): `wr_cnt`+1, go to IDLE. Writes are posted; the next request waits on `iob_ready_i` naturally.
  - On `iob_ready_i`=1 with a read: `rd_cnt`+1, clear the timeout counter, go to WAIT_RD.
- WAIT_RD: on `iob_rvalid_i`=1, capture `iob_rdata_i` into the response register and go to RSP. Each cycle without it, the timeout counter increments, saturating at `TIMEOUT`.
  - On reaching `TIMEOUT` (when `TIMEOUT`≠0), set `timeout_o`. The FSM keeps waiting; there is no abort.
- RSP: `rsp_valid_o`=1 with the captured data. On `rsp_ready_i`=1, go to IDLE. No new command is accepted in RSP.
- Unexpected `iob_rvalid_i`=1 in IDLE, REQ or RSP sets `err_o`. The data is discarded and the FSM is unaffected.
- `clr_i`: zeroes `rd_cnt_o`, `wr_cnt_o`, `timeout_o` and `err_o`. It wins over a same-cycle increment or flag set. It does not affect the FSM.
- Counters are unsigned, modulo 2^CNT_W: `all-ones`+1 wraps to 0 with no flag.

## Timing
- Reset values: `cmd_ready_o`=1, all other outputs 0 (including `iob_*` data fields and the response register).
- Command handshake in cycle N gives `iob_avalid_o`=1 in N+1. With `iob_ready_i` held 1, the bus accept is in N+1.
- A read accepted at cycle M with `iob_rvalid_i` at M+k (k≥1) gives `rsp_valid_o`=1 at M+k+1.
- `rsp_ready_i` in the first RSP cycle gives `cmd_ready_o`=1 the next cycle. Read throughput is one read per k+3 cycles.
- A write accepted at cycle M gives `cmd_ready_o`=1 at M+1, so the write throughput limit is 2 cycles per write.
- `rsp_valid_o` stays high and `rsp_rdata_o` stays stable while `rsp_ready_i`=0.
- `rst_i` mid-transaction returns the FSM to IDLE the next cycle and drops `iob_avalid_o` and `rsp_valid_o`. An in-flight read response arriving afterwards sets `err_o`.
- With `cke_i`=0, all state, counters and outputs hold.

## Test plan
- Write 0xDEADBEEF to 0x100, wstrb=0xF, `iob_ready_i`=1 → `iob_avalid_o` for exactly one cycle at N+1 with matching fields; `wr_cnt_o`=1; `cmd_ready_o`=1 at N+2.
- Read 0x200, `iob_ready_i` low 3 cycles, `iob_rvalid_i` 2 cycles after accept with 0x12345678 → avalid held 4 cycles with stable fields; `rsp_rdata_o`=0x12345678; `rd_cnt_o`=1.
- Read response with `rsp_ready_i` low 5 cycles, `cmd_valid_i` high → `rsp_valid_o` and data held; `cmd_ready_o`=0 until the cycle after `rsp_ready_i`.
- `TIMEOUT`=8, `iob_rvalid_i` withheld 20 cycles then delivered → `timeout_o`=1 from wait cycle 8; response still delivered; `clr_i` clears the flag.
- `iob_rvalid_i` pulse in IDLE → `err_o`=1 and no `rsp_valid_o`. Then `rst_i` during WAIT_RD → FSM in IDLE next cycle and all outputs at reset values.
- `CNT_W`=4, 17 writes → `wr_cnt_o`=1. `clr_i` asserted in the same cycle as a write accept → `wr_cnt_o`=0.
